// File: rtl/fifo_sync_param.sv
// Synchronous FIFO with registered read port, occupancy count, threshold flags and sticky errors.
// Define FIFO_SYNC_PARAM_FWFT_EN to build a first-word-fall-through variant.
module fifo_sync_param #(
    parameter int unsigned WIDTH    = 36,
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned AF_LEVEL = DEPTH - 4,
    parameter int unsigned AE_LEVEL = 4,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    output logic             full,
    output logic             almost_full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam logic [AW:0] PtrOne   = (AW + 1)'(1);
    localparam logic [AW:0] AfLevel  = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] AeLevel  = (AW + 1)'(AE_LEVEL);
    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic ram_empty;
    logic ptr_full;
    logic wr_accept;
    logic ram_rd;
    logic drop_rd;

    assign ram_empty = (wr_ptr_q == rd_ptr_q);
    assign ptr_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

`ifdef FIFO_SYNC_PARAM_FWFT_EN
    // Output register holds the head word, so it is part of the occupancy.
    assign count   = (wr_ptr_q - rd_ptr_q) + (AW + 1)'(rd_valid_q);
    assign full    = (count == DepthCnt);
    assign empty   = !rd_valid_q;
    assign ram_rd  = !ram_empty && (!rd_valid_q || rd_en);
    assign drop_rd = rd_en && !rd_valid_q;
`else
    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = ptr_full;
    assign empty   = ram_empty;
    assign ram_rd  = rd_en && !ram_empty;
    assign drop_rd = rd_en && ram_empty;
`endif

    assign wr_accept    = wr_en && !full;
    assign almost_full  = (count >= AfLevel);
    assign almost_empty = (count <= AeLevel);
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (ram_rd) begin
            rd_ptr_d  = rd_ptr_q + PtrOne;
            rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
        end
`ifdef FIFO_SYNC_PARAM_FWFT_EN
        // Head stays valid until acknowledged, unless a refill replaces it.
        rd_valid_d = ram_rd || (rd_valid_q && !rd_en);
`else
        rd_valid_d = ram_rd;
`endif
        // A new error event in the same cycle as err_clr keeps the flag set.
        overflow_d  = (wr_en && full) || (overflow_q && !err_clr);
        underflow_d = drop_rd || (underflow_q && !err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (WIDTH=8, DEPTH=8, AF=6, AE=2) using a data scoreboard
// plus a small occupancy/error-flag model.
module tb_fifo_sync_param;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 8;
    localparam int unsigned AF = 6;
    localparam int unsigned AE = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] wr_data;
    logic         wr_en;
    logic         full;
    logic         almost_full;
    logic         rd_en;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         empty;
    logic         almost_empty;
    logic [3:0]   count;
    logic         overflow;
    logic         underflow;
    logic         err_clr;

    fifo_sync_param #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .full         (full),
        .almost_full  (almost_full),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    logic [W-1:0] sb[$];
    int unsigned  m_cnt   = 0;
    logic         m_ovf   = 1'b0;
    logic         m_unf   = 1'b0;
    logic [W-1:0] m_rdata = '0;
    int unsigned  n_pops  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input logic exp_valid);
        check_eq("count", 32'(count), 32'(m_cnt));
        check_eq("full", 32'(full), 32'(m_cnt == D));
        check_eq("empty", 32'(empty), 32'(m_cnt == 0));
        check_eq("almost_full", 32'(almost_full), 32'(m_cnt >= AF));
        check_eq("almost_empty", 32'(almost_empty), 32'(m_cnt <= AE));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("underflow", 32'(underflow), 32'(m_unf));
        check_eq("rd_valid", 32'(rd_valid), 32'(exp_valid));
        check_eq("rd_data", 32'(rd_data), 32'(m_rdata));
    endtask

    // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
    task automatic cycle(input logic w, input logic [W-1:0] d, input logic r, input logic c);
        logic full_m, empty_m, wa, ra;
        full_m  = (m_cnt == D);
        empty_m = (m_cnt == 0);
        wa      = w && !full_m;
        ra      = r && !empty_m;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        err_clr = c;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        m_ovf   = (w && full_m) || (m_ovf && !c);
        m_unf   = (r && empty_m) || (m_unf && !c);
        if (ra) begin
            m_rdata = sb.pop_front();
            n_pops++;
        end
        if (wa) sb.push_back(d);
        m_cnt = sb.size();
        check_outputs(ra);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs(1'b0);
        rst = 1'b0;

`ifdef FIFO_SYNC_PARAM_FWFT_EN
        wr_en   = 1'b1;
        wr_data = 8'h5A;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check_eq("fwft_valid_early", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1;
        check_eq("fwft_valid", 32'(rd_valid), 32'd1);
        check_eq("fwft_data", 32'(rd_data), 32'h5A);
        check_eq("fwft_count", 32'(count), 32'd1);
        check_eq("fwft_empty", 32'(empty), 32'd0);
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        check_eq("fwft_valid_drop", 32'(rd_valid), 32'd0);
        check_eq("fwft_empty_after", 32'(empty), 32'd1);
        check_eq("fwft_count_after", 32'(count), 32'd0);
`else
        // Fill, then overflow on the 9th write.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'h09, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        // Set beats clear in the same cycle.
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        // Simultaneous at full: read only; then both; then refill to full.
        cycle(1'b1, 8'h10, 1'b1, 1'b0);
        cycle(1'b1, 8'h11, 1'b1, 1'b0);
        cycle(1'b1, 8'h12, 1'b0, 1'b1);
        // Drain and one extra read.
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        // Simultaneous at empty: write only.
        cycle(1'b1, 8'h20, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h24, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Random interleave of 20 writes and 20 reads across pointer wrap.
        begin
            int unsigned wn = 0;
            int unsigned start = n_pops;
            for (int k = 0; k < 400 && (n_pops - start) < 20; k++) begin
                logic w, r;
                w = (wn < 20) && ($urandom_range(0, 2) != 0);
                r = ($urandom_range(0, 2) != 0);
                if (w && m_cnt < D) begin
                    cycle(1'b1, 8'(8'h30 + wn), r, 1'b1);
                    wn++;
                end else begin
                    cycle(1'b0, 8'h00, r, 1'b1);
                end
            end
            check_eq("interleave_reads", n_pops - start, 32'd20);
        end

        // Asynchronous reset mid-stream at count=5.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        sb.delete();
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rdata = '0;
        check_outputs(1'b0);
        #2;
        rst = 1'b0;
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check_eq("post_reset_data", 32'(rd_data), 32'hAA);
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
